// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// master: the issuing stage (decode/register-read side plus writeback ready).
// slave:  the ALU itself.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] inreg_1;
   logic [WIDTH-1:0] inreg_2;
   logic [SHW-1:0]   shamt;
   logic [3:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] outreg;
   logic             flag;
   logic             busy;

   modport master (
      output in_valid, inreg_1, inreg_2, shamt, alu_op, out_ready,
      input  in_ready, out_valid, outreg, flag, busy
   );

   modport slave (
      input  in_valid, inreg_1, inreg_2, shamt, alu_op, out_ready,
      output in_ready, out_valid, outreg, flag, busy
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready on both sides.
// Single-cycle ops (ADD, COMP, AND, XOR, SLL, SRL, SRA) register their result at
// the accept edge; DIFF scans A^B one bit per cycle for the lowest set bit.
// Optional feature macro: ALU_SEQ_MUL_EN adds a shift-add MUL on alu_op=4'b1000.
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// SCAN  | DIFF bit scan, cnt walks x from bit 0 upward
// MUL   | shift-add multiply, one bit of B per cycle (ALU_SEQ_MUL_EN only)
// DONE  | result presented, held until out_ready
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
`ifdef ALU_SEQ_MUL_EN
      MUL  = 2'd2,
`endif
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] x;
   logic [SHW-1:0]   cnt;
   logic             accept;
   logic             is_diff;

   logic [WIDTH-1:0] amt;
   logic             amt_big;
   logic [SHW-1:0]   sh;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             res_flag;

`ifdef ALU_SEQ_MUL_EN
   logic               is_mul;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod;

   assign is_mul = (bus.alu_op == 4'b1000);

   // Partial-product accumulation for the current multiplier bit.
   always_comb begin
      prod = acc;
      if (op_b[cnt]) prod = acc + ({{WIDTH{1'b0}}, op_a} << cnt);
   end
`endif

   assign accept  = bus.in_valid && (state == IDLE);
   assign is_diff = (bus.alu_op[2:0] == 3'b111);

   // Single-cycle result from the live inputs; only sampled at the accept edge.
   always_comb begin
      amt      = bus.alu_op[3] ? bus.inreg_2 : WIDTH'(bus.shamt);
      amt_big  = |amt[WIDTH-1:SHW];
      sh       = amt[SHW-1:0];
      sum      = {1'b0, bus.inreg_1} + {1'b0, bus.inreg_2};
      res      = '0;
      res_flag = 1'b0;
      case (bus.alu_op[2:0])
         3'b000: begin
            res      = sum[WIDTH-1:0];
            res_flag = sum[WIDTH];
         end
         3'b001: res = ~bus.inreg_2 + WIDTH'(1);
         3'b010: res = bus.inreg_1 & bus.inreg_2;
         3'b011: res = bus.inreg_1 ^ bus.inreg_2;
         3'b100: res = amt_big ? '0 : (bus.inreg_1 << sh);
         3'b101: res = amt_big ? '0 : (bus.inreg_1 >> sh);
         3'b110: res = amt_big ? {WIDTH{bus.inreg_1[WIDTH-1]}}
                               : $unsigned($signed(bus.inreg_1) >>> sh);
         default: res = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_diff) state_nxt = SCAN;
`ifdef ALU_SEQ_MUL_EN
               else if (is_mul) state_nxt = MUL;
`endif
               else state_nxt = DONE;
            end
         end
         SCAN: if (x[cnt] || (cnt == CNT_LAST)) state_nxt = DONE;
`ifdef ALU_SEQ_MUL_EN
         MUL:  if (cnt == CNT_LAST) state_nxt = DONE;
`endif
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure functions of state.
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state != IDLE);
   end

   // Operand capture, iteration counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         x          <= '0;
         cnt        <= '0;
         bus.outreg <= '0;
         bus.flag   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         op_a       <= '0;
         op_b       <= '0;
         acc        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt <= '0;
                  if (is_diff) begin
                     x <= bus.inreg_1 ^ bus.inreg_2;
                  end
`ifdef ALU_SEQ_MUL_EN
                  else if (is_mul) begin
                     op_a <= bus.inreg_1;
                     op_b <= bus.inreg_2;
                     acc  <= '0;
                  end
`endif
                  else begin
                     bus.outreg <= res;
                     bus.flag   <= res_flag;
                  end
               end
            end
            SCAN: begin
               if (x[cnt]) begin
                  bus.outreg <= WIDTH'(cnt);
                  bus.flag   <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  bus.outreg <= WIDTH'(WIDTH);
                  bus.flag   <= 1'b1;
               end else begin
                  cnt <= cnt + SHW'(1);
               end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               acc <= prod;
               if (cnt == CNT_LAST) begin
                  bus.outreg <= prod[WIDTH-1:0];
                  bus.flag   <= |prod[2*WIDTH-1:WIDTH];
               end else begin
                  cnt <= cnt + SHW'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=32) with directed corner
// cases; MUL cases run only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: results from plain arithmetic, shifts as repeated one-bit moves.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [3:0] op,
                                 output logic [31:0] r, output logic f, output int lat);
      logic [63:0] s;
      logic [31:0] amt;
      logic [31:0] v;
      logic [31:0] d;
      bit          found;
      amt = op[3] ? b : {27'b0, sh};
      r   = '0;
      f   = 1'b0;
      lat = 1;
      v   = a;
      case (op[2:0])
         3'd0: begin
            s = {32'b0, a} + {32'b0, b};
            r = s[31:0];
            f = s[32];
         end
         3'd1: r = 32'd0 - b;
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         3'd4: begin
            for (int i = 0; i < 32 && i < amt; i++) v = {v[30:0], 1'b0};
            r = v;
         end
         3'd5: begin
            for (int i = 0; i < 32 && i < amt; i++) v = {1'b0, v[31:1]};
            r = v;
         end
         3'd6: begin
            for (int i = 0; i < 32 && i < amt; i++) v = {v[31], v[31:1]};
            r = v;
         end
         default: begin
            d     = a ^ b;
            found = 1'b0;
            for (int i = 0; i < 32; i++) begin
               if (!found && d[i]) begin
                  found = 1'b1;
                  r     = 32'(i);
                  lat   = i + 2;
               end
            end
            if (!found) begin
               r   = 32'd32;
               f   = 1'b1;
               lat = 33;
            end
         end
      endcase
`ifdef ALU_SEQ_MUL_EN
      if (op == 4'b1000) begin
         s   = {32'b0, a} * {32'b0, b};
         r   = s[31:0];
         f   = |s[63:32];
         lat = 33;
      end
`endif
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [3:0] op, input int hold,
                         output logic [31:0] r, output logic f, output int lat);
      logic [31:0] er;
      logic        ef;
      int          el;
      model(a, b, sh, op, er, ef, el);
      @(negedge clk);
      chk("in_ready_idle", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.inreg_1   = a;
      bus.inreg_2   = b;
      bus.shamt     = sh;
      bus.alu_op    = op;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.inreg_1  = $urandom;
      bus.inreg_2  = $urandom;
      bus.shamt    = 5'($urandom);
      bus.alu_op   = 4'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = bus.outreg;
      f = bus.flag;
      chk("result", r, er);
      chk("flag", f, ef);
      chk("latency", lat, el);
      chk("busy_done", bus.busy, 1);
      chk("in_ready_done", bus.in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_result", bus.outreg, er);
         chk("hold_flag", bus.flag, ef);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("release_out_valid", bus.out_valid, 0);
      chk("release_in_ready", bus.in_ready, 1);
      chk("release_busy", bus.busy, 0);
   endtask

   initial begin
      logic [31:0] r;
      logic        f;
      int          lat;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.inreg_1   = '0;
      bus.inreg_2   = '0;
      bus.shamt     = '0;
      bus.alu_op    = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_outreg", bus.outreg, 0);
      chk("rst_flag", bus.flag, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;

      run_op(32'hFFFF_FFFF, 32'h1, 5'd0, 4'b0000, 0, r, f, lat);
      chk("t1_add_res", r, 0);
      chk("t1_add_carry", f, 1);
      chk("t1_add_lat", lat, 1);

      run_op(32'h8000_0000, 32'd40, 5'd0, 4'b1110, 0, r, f, lat);
      chk("t2_sra_big", r, 32'hFFFF_FFFF);
      run_op(32'h8000_0000, 32'd40, 5'd0, 4'b1101, 0, r, f, lat);
      chk("t2_srl_big", r, 0);

      run_op(32'h10, 32'h0, 5'd0, 4'b0111, 0, r, f, lat);
      chk("t3_diff_res", r, 4);
      chk("t3_diff_flag", f, 0);
      chk("t3_diff_lat", lat, 6);
      run_op(32'h5A5A, 32'h5A5A, 5'd0, 4'b0111, 0, r, f, lat);
      chk("t3_eq_res", r, 32);
      chk("t3_eq_flag", f, 1);
      chk("t3_eq_lat", lat, 33);

      run_op(32'hF0, 32'h0F, 5'd0, 4'b0011, 5, r, f, lat);
      chk("t4_xor_res", r, 32'hFF);

      // Abort a DIFF whose first differing bit is 20, while cnt=10.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.inreg_1  = 32'h0;
      bus.inreg_2  = 32'h0010_0000;
      bus.alu_op   = 4'b0111;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t5_busy_scan", bus.busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_rst_out_valid", bus.out_valid, 0);
      chk("t5_rst_outreg", bus.outreg, 0);
      chk("t5_rst_in_ready", bus.in_ready, 1);
      chk("t5_rst_busy", bus.busy, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_late_result", bus.out_valid, 0);
      run_op(32'd3, 32'd4, 5'd0, 4'b0000, 0, r, f, lat);
      chk("t5_add_after_rst", r, 7);

`ifdef ALU_SEQ_MUL_EN
      run_op(32'h0001_0000, 32'h0001_0000, 5'd0, 4'b1000, 0, r, f, lat);
      chk("t6_mul_ovf_res", r, 0);
      chk("t6_mul_ovf_flag", f, 1);
      chk("t6_mul_lat", lat, 33);
      run_op(32'd7, 32'd6, 5'd0, 4'b1000, 0, r, f, lat);
      chk("t6_mul_res", r, 42);
      chk("t6_mul_flag", f, 0);
`endif

      for (int n = 0; n < 80; n++) begin
         a  = $urandom;
         b  = $urandom;
         op = 4'($urandom_range(0, 15));
         if (op[2:0] == 3'b111) begin
            case ($urandom_range(0, 2))
               0: b = a ^ (32'd1 << $urandom_range(0, 31));
               1: b = a;
               default: ;
            endcase
         end
         if (op[3] && (op[2:0] inside {3'd4, 3'd5, 3'd6}) && $urandom_range(0, 1) == 1)
            b = $urandom_range(0, 40);
         run_op(a, b, 5'($urandom), op, $urandom_range(0, 2), r, f, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
